// File: rtl/vga_timing.sv
// Parametrised VGA raster timing generator: h/v/frame counters advanced by a pixel
// enable, decoded into sync/visible/strobe outputs and delayed DELAY enabled clocks.
module vga_timing #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int H_SYNC_POL  = 0,
  parameter int V_SYNC_POL  = 0,
  parameter int COUNT_WIDTH = 10,
  parameter int FRAME_WIDTH = 10,
  parameter int DELAY       = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pixel_en,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   h_visible,
  output logic                   v_visible,
  output logic                   visible,
  output logic [COUNT_WIDTH-1:0] h_count,
  output logic [COUNT_WIDTH-1:0] v_count,
  output logic [FRAME_WIDTH-1:0] frame_count,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   vblank_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COUNT_WIDTH-1:0] H_LAST       = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST       = COUNT_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] H_VIS_END    = COUNT_WIDTH'(H_VISIBLE);
  localparam logic [COUNT_WIDTH-1:0] V_VIS_END    = COUNT_WIDTH'(V_VISIBLE);
  localparam logic [COUNT_WIDTH-1:0] H_SYNC_START = COUNT_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [COUNT_WIDTH-1:0] H_SYNC_END   = COUNT_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COUNT_WIDTH-1:0] V_SYNC_START = COUNT_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [COUNT_WIDTH-1:0] V_SYNC_END   = COUNT_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic H_ACTIVE = (H_SYNC_POL != 0);
  localparam logic V_ACTIVE = (V_SYNC_POL != 0);

  // One pipeline stage: everything describing a single beam position.
  typedef struct packed {
    logic                   h_sync;
    logic                   v_sync;
    logic                   h_visible;
    logic                   v_visible;
    logic                   visible;
    logic [COUNT_WIDTH-1:0] h_count;
    logic [COUNT_WIDTH-1:0] v_count;
    logic [FRAME_WIDTH-1:0] frame_count;
    logic                   line_start;
    logic                   frame_start;
    logic                   vblank_start;
  } raster_t;

  function automatic raster_t idle_value();
    raster_t r;
    r        = '0;
    r.h_sync = ~H_ACTIVE;
    r.v_sync = ~V_ACTIVE;
    return r;
  endfunction

  localparam raster_t IDLE = idle_value();

  logic [COUNT_WIDTH-1:0] h;
  logic [COUNT_WIDTH-1:0] v;
  logic [FRAME_WIDTH-1:0] frame;
  logic                   h_last;
  logic                   v_last;
  raster_t                decoded;
  raster_t                pipe [DELAY];

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h     <= '0;
      v     <= '0;
      frame <= '0;
    end else if (pixel_en) begin
      if (h_last) begin
        h <= '0;
        if (v_last) begin
          v     <= '0;
          frame <= frame + 1'b1;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_comb begin
    decoded              = IDLE;
    decoded.h_sync       = ((h >= H_SYNC_START) && (h < H_SYNC_END)) ? H_ACTIVE : ~H_ACTIVE;
    decoded.v_sync       = ((v >= V_SYNC_START) && (v < V_SYNC_END)) ? V_ACTIVE : ~V_ACTIVE;
    decoded.h_visible    = (h < H_VIS_END);
    decoded.v_visible    = (v < V_VIS_END);
    decoded.visible      = (h < H_VIS_END) && (v < V_VIS_END);
    decoded.h_count      = h;
    decoded.v_count      = v;
    decoded.frame_count  = frame;
    decoded.line_start   = (h == '0);
    decoded.frame_start  = (h == '0) && (v == '0);
    decoded.vblank_start = (h == '0) && (v == V_VIS_END);
  end

  // Stages only shift on enabled cycles, so strobes stretch with a slow pixel_en.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DELAY; i++) pipe[i] <= IDLE;
    end else if (pixel_en) begin
      pipe[0] <= decoded;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign h_sync       = pipe[DELAY-1].h_sync;
  assign v_sync       = pipe[DELAY-1].v_sync;
  assign h_visible    = pipe[DELAY-1].h_visible;
  assign v_visible    = pipe[DELAY-1].v_visible;
  assign visible      = pipe[DELAY-1].visible;
  assign h_count      = pipe[DELAY-1].h_count;
  assign v_count      = pipe[DELAY-1].v_count;
  assign frame_count  = pipe[DELAY-1].frame_count;
  assign line_start   = pipe[DELAY-1].line_start;
  assign frame_start  = pipe[DELAY-1].frame_start;
  assign vblank_start = pipe[DELAY-1].vblank_start;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: two small-raster instances (DELAY=1 active-low, DELAY=3 active-high)
// checked every clock against an arithmetic raster model driven by the enabled-cycle count.
module tb_vga_timing;

  localparam int HV = 16, HF = 4, HS = 4, HB = 4;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int CW = 6;

  logic clock;
  logic reset;
  logic pixel_en;

  logic          hs_a, vs_a, hv_a, vv_a, vis_a, ls_a, fs_a, vbs_a;
  logic [CW-1:0] hc_a, vc_a;
  logic [1:0]    fc_a;
  logic          hs_b, vs_b, hv_b, vv_b, vis_b, ls_b, fs_b, vbs_b;
  logic [CW-1:0] hc_b, vc_b;
  logic [2:0]    fc_b;
  logic [23:0]   obs_a, obs_b;

  int     n_cmp;
  int     n_err;
  longint k;

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .COUNT_WIDTH(CW), .FRAME_WIDTH(2), .DELAY(1)
  ) dut_a (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .h_sync(hs_a), .v_sync(vs_a), .h_visible(hv_a), .v_visible(vv_a), .visible(vis_a),
    .h_count(hc_a), .v_count(vc_a), .frame_count(fc_a),
    .line_start(ls_a), .frame_start(fs_a), .vblank_start(vbs_a)
  );

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .COUNT_WIDTH(CW), .FRAME_WIDTH(3), .DELAY(3)
  ) dut_b (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .h_sync(hs_b), .v_sync(vs_b), .h_visible(hv_b), .v_visible(vv_b), .visible(vis_b),
    .h_count(hc_b), .v_count(vc_b), .frame_count(fc_b),
    .line_start(ls_b), .frame_start(fs_b), .vblank_start(vbs_b)
  );

  assign obs_a = {hs_a, vs_a, hv_a, vv_a, vis_a, hc_a, vc_a, 2'b00, fc_a, ls_a, fs_a, vbs_a};
  assign obs_b = {hs_b, vs_b, hv_b, vv_b, vis_b, hc_b, vc_b, 1'b0, fc_b, ls_b, fs_b, vbs_b};

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: k enabled clocks after release, outputs show raster position k-delay.
  function automatic logic [23:0] model(input longint kk, input int delay,
                                        input logic hpol, input logic vpol, input int fw);
    longint p, h, line, v, f;
    logic   hs, vs, hvis, vvis;
    if (kk < delay) return {~hpol, ~vpol, 22'b0};
    p    = kk - delay;
    h    = p % HT;
    line = p / HT;
    v    = line % VT;
    f    = (line / VT) % (longint'(1) << fw);
    hs   = (h >= HV + HF && h < HV + HF + HS) ? hpol : ~hpol;
    vs   = (v >= VV + VF && v < VV + VF + VS) ? vpol : ~vpol;
    hvis = (h < HV);
    vvis = (v < VV);
    return {hs, vs, hvis, vvis, hvis & vvis, 6'(h), 6'(v), 4'(f),
            h == 0, (h == 0) && (v == 0), (h == 0) && (v == VV)};
  endfunction

  // Driver: one clock with the given enable, ending on the falling edge.
  task automatic tick(input logic en);
    pixel_en = en;
    @(posedge clock);
    if (en && !reset) k++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      n_cmp++;
      if (obs_a !== model(0, 1, 1'b0, 1'b0, 2)) begin
        n_err++;
        $display("FAIL reset_idle_a: got %h want %h", obs_a, model(0, 1, 1'b0, 1'b0, 2));
      end
      n_cmp++;
      if (obs_b !== model(0, 3, 1'b1, 1'b1, 3)) begin
        n_err++;
        $display("FAIL reset_idle_b: got %h want %h", obs_b, model(0, 3, 1'b1, 1'b1, 3));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_startup();
    tick(1'b1);
    n_cmp++;
    if ({ls_a, fs_a, hc_a, vc_a} !== {1'b1, 1'b1, 6'd0, 6'd0}) begin
      n_err++;
      $display("FAIL startup_a: got ls=%b fs=%b h=%0d v=%0d want ls=1 fs=1 h=0 v=0",
               ls_a, fs_a, hc_a, vc_a);
    end
    n_cmp++;
    if (obs_b !== model(k, 3, 1'b1, 1'b1, 3)) begin
      n_err++;
      $display("FAIL startup_b: got %h want %h", obs_b, model(k, 3, 1'b1, 1'b1, 3));
    end
  endtask

  // mode 0: pixel_en always high, 1: alternating 1/0, 2: random
  task automatic test_raster(input int cycles, input int mode);
    logic en;
    for (int i = 0; i < cycles; i++) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = (i % 2 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      tick(en);
      n_cmp++;
      if (obs_a !== model(k, 1, 1'b0, 1'b0, 2)) begin
        n_err++;
        $display("FAIL raster_a k=%0d: got %h want %h", k, obs_a, model(k, 1, 1'b0, 1'b0, 2));
      end
      n_cmp++;
      if (obs_b !== model(k, 3, 1'b1, 1'b1, 3)) begin
        n_err++;
        $display("FAIL raster_b k=%0d: got %h want %h", k, obs_b, model(k, 3, 1'b1, 1'b1, 3));
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    // Move to line 5 of a frame, then hit reset between clock edges.
    while (((k / HT) % VT) != 5 && guard < 2000) begin
      tick(1'b1);
      guard++;
    end
    n_cmp++;
    if (guard >= 2000) begin
      n_err++;
      $display("FAIL async_reset_reach: got guard=%0d want <2000", guard);
    end
    #2 reset = 1'b1;
    #1;
    k = 0;
    n_cmp++;
    if (obs_a !== model(0, 1, 1'b0, 1'b0, 2)) begin
      n_err++;
      $display("FAIL async_reset_a: got %h want %h", obs_a, model(0, 1, 1'b0, 1'b0, 2));
    end
    n_cmp++;
    if (obs_b !== model(0, 3, 1'b1, 1'b1, 3)) begin
      n_err++;
      $display("FAIL async_reset_b: got %h want %h", obs_b, model(0, 3, 1'b1, 1'b1, 3));
    end
    @(negedge clock);
    tick(1'b1);
    reset = 1'b0;
    test_raster(3 * HT, 2);
  endtask

  task automatic test_frame_wrap();
    int frames;
    frames = 0;
    reset  = 1'b1;
    tick(1'b1);
    k      = 0;
    reset  = 1'b0;
    for (int i = 0; i < 5 * HT * VT + 2; i++) begin
      tick(1'b1);
      if (fs_a) begin
        n_cmp++;
        if (fc_a !== 2'(frames % 4)) begin
          n_err++;
          $display("FAIL frame_wrap: got frame_count=%0d want %0d", fc_a, frames % 4);
        end
        frames++;
      end
    end
    n_cmp++;
    if (frames != 6) begin
      n_err++;
      $display("FAIL frame_start_count: got %0d want 6", frames);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    k        = 0;
    reset    = 1'b1;
    pixel_en = 1'b1;
    @(negedge clock);
    test_reset();
    test_startup();
    test_raster(HT * VT + 100, 0);
    test_raster(2 * HT * VT, 1);
    test_raster(2 * HT * VT, 2);
    test_async_reset();
    test_raster(2 * HT * VT, 2);
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
